// File: rtl/fpalu_pkg.sv
// fpalu_pkg: binary32 field widths, constants and field struct shared by the adder.
package fpalu_pkg;
   localparam int EXP_W = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS = 127;
   localparam int EXP_MAX = 255;
   localparam logic [31:0] QNAN = 32'h7FC00000;
   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;
endpackage

// File: rtl/fpalu_lzc.sv
// fpalu_lzc: leading-zero count over the 27-bit mantissa/guard/round/sticky sum.
module fpalu_lzc (
   input  logic [26:0] x,
   output logic [4:0]  lz
);
   always_comb begin
      lz = 5'd27;
      for (int i = 0; i < 27; i++)
         if (x[i]) lz = 5'(26 - i);
   end
endmodule

// File: rtl/fpalu.sv
// fpalu: single-cycle binary32 add/subtract, round-to-nearest-even, flush-to-zero.
module fpalu
   import fpalu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        op,
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] out,
   output logic        o
);
   fp32_t fa, fb, big, sml;
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
   logic [23:0] mb, ms;
   logic [7:0] d;
   logic [49:0] wide;
   logic [26:0] aln, m;
   logic [27:0] sum;
   logic [4:0] lz;
   logic [9:0] e, ef;
   logic up;
   logic [24:0] rnd;
   logic [22:0] frac;
   logic [31:0] nxt;
   logic nxt_o;
   assign fa = a;
   assign fb = {b[31] ^ op, b[30:0]};
   assign a_zero = fa.exp == '0;
   assign b_zero = fb.exp == '0;
   assign a_inf = fa.exp == EXP_W'(EXP_MAX) && fa.frac == '0;
   assign b_inf = fb.exp == EXP_W'(EXP_MAX) && fb.frac == '0;
   assign a_nan = fa.exp == EXP_W'(EXP_MAX) && fa.frac != '0;
   assign b_nan = fb.exp == EXP_W'(EXP_MAX) && fb.frac != '0;
   assign swap = fb[30:0] > fa[30:0];
   assign big = swap ? fb : fa;
   assign sml = swap ? fa : fb;
   assign mb = {1'b1, big.frac};
   assign ms = {1'b1, sml.frac};
   assign d = big.exp - sml.exp;
   // Bits shifted past the 27-bit window fold into sticky; 26+ leaves sticky alone.
   assign wide = {ms, 26'd0} >> d;
   assign aln = d >= 8'd26 ? 27'd1 : {wide[49:24], |wide[23:0]};
   assign sum = big.sign == sml.sign ? {1'b0, mb, 3'd0} + {1'b0, aln}
                                     : {1'b0, mb, 3'd0} - {1'b0, aln};
   fpalu_lzc u_lzc (.x(sum[26:0]), .lz(lz));
   assign m = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << lz;
   assign e = sum[27] ? {2'd0, big.exp} + 10'd1 : {2'd0, big.exp} - {5'd0, lz};
   assign up = m[2] & (m[1] | m[0] | m[3]);
   assign rnd = {1'b0, m[26:3]} + {24'd0, up};
   assign frac = rnd[24] ? rnd[23:1] : rnd[22:0];
   assign ef = e + {9'd0, rnd[24]};
   always_comb begin
      nxt_o = 1'b0;
      nxt = {big.sign, ef[7:0], frac};
      if (a_nan || b_nan || (a_inf && b_inf && fa.sign != fb.sign)) nxt = QNAN;
      else if (a_inf) nxt = fa;
      else if (b_inf) nxt = fb;
      else if (b_zero) nxt = a_zero ? {fa.sign, 31'd0} : fa;
      else if (a_zero) nxt = fb;
      else if (sum == '0) nxt = '0;
      else if ($signed(ef) >= $signed(10'(EXP_MAX))) begin
         nxt = {big.sign, 8'hFF, 23'd0};
         nxt_o = 1'b1;
      end
      else if ($signed(ef) <= 10'sd0) nxt = '0;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         out <= '0;
         o <= 1'b0;
      end else begin
         out <= nxt;
         o <= nxt_o;
      end
endmodule

// File: tb/tb_fpalu.sv
// tb_fpalu: directed binary32 add/subtract vectors with hand-computed results.
module tb_fpalu;
   logic [31:0] a = '0, b = '0, out;
   logic op = 1'b0, clk = 1'b0, rst = 1'b1, o;
   int total = 0, bad = 0;
   fpalu dut (.a(a), .b(b), .op(op), .clk(clk), .rst(rst), .out(out), .o(o));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] eo, input logic eov);
      total++;
      assert (out === eo && o === eov) else begin
         bad++;
         $error("FAIL %s: out=%h o=%b expected out=%h o=%b", tag, out, o, eo, eov);
      end
   endtask
   task automatic step(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic vop, input logic [31:0] eo, input logic eov);
      @(negedge clk);
      a = va;
      b = vb;
      op = vop;
      @(posedge clk);
      #1 chk(tag, eo, eov);
   endtask
   initial begin
      #1 rst = 1'b0;
      #1 chk("reset_async", 32'h0, 1'b0);
      a = 32'h3F800000;
      b = 32'h3F800000;
      @(posedge clk);
      #1 chk("reset_held", 32'h0, 1'b0);
      @(negedge clk) rst = 1'b1;
      step("add_1_2", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
      @(negedge clk);
      a = 32'h40400000;
      b = 32'h3F800000;
      op = 1'b1;
      #1 chk("latency_hold", 32'h40400000, 1'b0);
      @(posedge clk);
      #1 chk("sub_3_1", 32'h40000000, 1'b0);
      step("cancel", 32'hD5551255, 32'hD5551250, 1'b1, 32'hCAA00000, 1'b0);
      step("ovf_pos", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1);
      step("ovf_neg", 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 1'b1);
      step("eq_sub_zero", 32'h0DEEEE00, 32'h0DEEEE00, 1'b1, 32'h00000000, 1'b0);
      step("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0);
      step("nan_in", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0);
      step("inf_p_1", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0);
      step("1_m_inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0);
      step("zero_m_1", 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0);
      step("pi_p_zero", 32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 1'b0);
      step("denorm_a", 32'h00000001, 32'h40000000, 1'b0, 32'h40000000, 1'b0);
      step("1_m_2", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0);
      step("tie_even_dn", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0);
      step("tie_odd_up", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0);
      step("sticky_only", 32'h3F800000, 32'h32000000, 1'b0, 32'h3F800000, 1'b0);
      step("round_carry", 32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 1'b0);
      step("flush_zero", 32'h80800001, 32'h80800000, 1'b1, 32'h00000000, 1'b0);
      step("pre_reset", 32'h40400000, 32'h40000000, 1'b0, 32'h40A00000, 1'b0);
      @(negedge clk);
      a = 32'h3F800000;
      b = 32'h3F800000;
      #2 rst = 1'b0;
      #1 chk("reset_mid", 32'h0, 1'b0);
      a = 'x;
      b = 'x;
      op = 1'bx;
      @(posedge clk);
      #1 chk("reset_x_in", 32'h0, 1'b0);
      step("reset_still", 32'h3F800000, 32'h40000000, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      a = 32'h3F800000;
      b = 32'h3F800000;
      op = 1'b0;
      @(posedge clk);
      #1 chk("first_after_rst", 32'h40000000, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
